// File: rtl/vicii_palette_encoder.sv
// Programmable VIC-II palette encoder: colour index -> luma / rotated chroma phase, two-stage pipeline.
// Defining VICII_PALETTE_READBACK_EN adds the cfg_re / cfg_rdata palette readback port.
module vicii_palette_encoder #(
  parameter int LUMA_W      = 5,
  parameter int CHROMA_W    = 5,
  parameter int IDX_W       = 4,
  parameter int PHASE_INC   = 4,
  parameter int BURST_PHASE = 'h10,
  parameter int PAL_MODE    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pix_valid,
  input  logic [IDX_W-1:0]         pixel,
  input  logic                     blank,
  input  logic                     burst,
  input  logic                     line_start,
  input  logic                     cfg_we,
  input  logic [IDX_W-1:0]         cfg_addr,
  input  logic [CHROMA_W+LUMA_W:0] cfg_data,
  output logic [LUMA_W-1:0]        luma,
  output logic [CHROMA_W-1:0]      chroma,
  output logic                     chroma_en,
`ifdef VICII_PALETTE_READBACK_EN
  output logic                     out_valid,
  input  logic                     cfg_re,
  output logic [CHROMA_W+LUMA_W:0] cfg_rdata
`else
  output logic                     out_valid
`endif
);

  localparam int DEPTH   = 1 << IDX_W;
  localparam int ENTRY_W = 1 + CHROMA_W + LUMA_W;
  localparam logic [CHROMA_W-1:0] PHASE_STEP = CHROMA_W'(PHASE_INC);
  localparam logic [CHROMA_W-1:0] BURST_REF  = CHROMA_W'(BURST_PHASE);

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic en, input int ph, input int lu);
    return {en, CHROMA_W'(ph), LUMA_W'(lu)};
  endfunction

  function automatic logic [ENTRY_W-1:0] default_entry(input int idx);
    case (idx)
      1:       return pack_entry(1'b0, 'h00, 31);
      2:       return pack_entry(1'b1, 'h09, 10);
      3:       return pack_entry(1'b1, 'h18, 20);
      4:       return pack_entry(1'b1, 'h02, 12);
      5:       return pack_entry(1'b1, 'h12, 16);
      6:       return pack_entry(1'b1, 'h00, 8);
      7:       return pack_entry(1'b1, 'h0D, 24);
      8:       return pack_entry(1'b1, 'h0A, 12);
      9:       return pack_entry(1'b1, 'h0B, 8);
      10:      return pack_entry(1'b1, 'h09, 16);
      11:      return pack_entry(1'b0, 'h00, 10);
      12:      return pack_entry(1'b0, 'h00, 15);
      13:      return pack_entry(1'b1, 'h12, 24);
      14:      return pack_entry(1'b1, 'h00, 15);
      15:      return pack_entry(1'b0, 'h00, 20);
      default: return '0;  // entry 0 is black; entries beyond the VIC-II set start cleared
    endcase
  endfunction

  // Odd PAL lines subtract the hue from the subcarrier instead of adding it.
  function automatic logic [CHROMA_W-1:0] rotate_phase(input logic [CHROMA_W-1:0] acc,
                                                       input logic [CHROMA_W-1:0] ph,
                                                       input logic odd);
    return odd ? (acc - ph) : (acc + ph);
  endfunction

  logic [ENTRY_W-1:0]  table_q [DEPTH];
  logic [CHROMA_W-1:0] acc_q, acc_d;
  logic                line_odd_q, line_odd_d;

  logic [ENTRY_W-1:0]  entry_p1_q;
  logic                blank_p1_q, burst_p1_q, vld_p1_q;

  logic [LUMA_W-1:0]   luma_p2_q, luma_d;
  logic [CHROMA_W-1:0] chroma_p2_q, chroma_d;
  logic                chroma_en_p2_q, chroma_en_d, vld_p2_q;

  logic                en_p1;
  logic [CHROMA_W-1:0] ph_p1;
  logic [LUMA_W-1:0]   lu_p1;

  assign acc_d      = acc_q + PHASE_STEP;
  assign line_odd_d = (PAL_MODE != 0) ? (line_odd_q ^ line_start) : 1'b0;
  assign {en_p1, ph_p1, lu_p1} = entry_p1_q;

  // Stage 2: resolve burst / blank / palette colour against the live subcarrier phase
  always_comb begin
    luma_d      = '0;
    chroma_d    = '0;
    chroma_en_d = 1'b0;
    if (burst_p1_q) begin
      chroma_en_d = 1'b1;
      chroma_d    = rotate_phase(acc_q, BURST_REF, line_odd_q);
    end else if (!blank_p1_q) begin
      luma_d = lu_p1;
      if (en_p1) begin
        chroma_en_d = 1'b1;
        chroma_d    = rotate_phase(acc_q, ph_p1, line_odd_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q          <= '0;
      line_odd_q     <= 1'b0;
      entry_p1_q     <= '0;
      blank_p1_q     <= 1'b0;
      burst_p1_q     <= 1'b0;
      vld_p1_q       <= 1'b0;
      luma_p2_q      <= '0;
      chroma_p2_q    <= '0;
      chroma_en_p2_q <= 1'b0;
      vld_p2_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) table_q[i] <= default_entry(i);
    end else begin
      acc_q          <= acc_d;
      line_odd_q     <= line_odd_d;
      // Stage 1: the lookup sees the table before this cycle's write lands
      entry_p1_q     <= table_q[pixel];
      blank_p1_q     <= blank;
      burst_p1_q     <= burst;
      vld_p1_q       <= pix_valid;
      luma_p2_q      <= luma_d;
      chroma_p2_q    <= chroma_d;
      chroma_en_p2_q <= chroma_en_d;
      vld_p2_q       <= vld_p1_q;
      if (cfg_we) table_q[cfg_addr] <= cfg_data;
    end
  end

  assign luma      = luma_p2_q;
  assign chroma    = chroma_p2_q;
  assign chroma_en = chroma_en_p2_q;
  assign out_valid = vld_p2_q;

`ifdef VICII_PALETTE_READBACK_EN
  logic [ENTRY_W-1:0] cfg_rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n)      cfg_rdata_q <= '0;
    else if (cfg_re) cfg_rdata_q <= table_q[cfg_addr];
  end

  assign cfg_rdata = cfg_rdata_q;
`endif

endmodule

// File: tb/tb_vicii_palette_encoder.sv
// Self-checking bench for vicii_palette_encoder: directed scenarios plus randomized traffic vs a history-based model.
module tb_vicii_palette_encoder;
  localparam int INC = 4;
  localparam int BPH = 'h10;
  localparam int PAL = 1;
  localparam int MOD = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic [3:0]  pixel = '0;
  logic        blank = 1'b0;
  logic        burst = 1'b0;
  logic        line_start = 1'b0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [10:0] cfg_data = '0;
  logic [4:0]  luma;
  logic [4:0]  chroma;
  logic        chroma_en;
  logic        out_valid;
`ifdef VICII_PALETTE_READBACK_EN
  logic        cfg_re = 1'b0;
  logic [10:0] cfg_rdata;
`endif

  vicii_palette_encoder dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pixel(pixel), .blank(blank),
    .burst(burst), .line_start(line_start), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .luma(luma), .chroma(chroma), .chroma_en(chroma_en),
`ifdef VICII_PALETTE_READBACK_EN
    .out_valid(out_valid), .cfg_re(cfg_re), .cfg_rdata(cfg_rdata)
`else
    .out_valid(out_valid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst; bit vld; bit blank; bit burst;
    int luma; int phase; bit en;
    int acc; bit odd;
  } snap_t;

  int def_luma  [16] = '{0, 31, 10, 20, 12, 16, 8, 24, 12, 8, 16, 10, 15, 24, 15, 20};
  int def_phase [16] = '{0, 0, 'h09, 'h18, 'h02, 'h12, 0, 'h0D, 'h0A, 'h0B, 'h09, 0, 0, 'h12, 0, 0};
  bit def_en    [16] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 0};

  int    m_luma [16];
  int    m_phase[16];
  bit    m_en   [16];
  int    since_rst = 0;
  int    lines_since_rst = 0;
  snap_t hist[$];
  int    ncmp = 0;
  int    nfail = 0;
  logic [11:0] exp_out = '0;
  logic [11:0] got;

  assign got = {luma, chroma, chroma_en, out_valid};

  // Output after an edge: pixel data from two cycles back, subcarrier state from the cycle just ended.
  function automatic logic [11:0] expect_out(snap_t s2, snap_t s1);
    int l, c;
    bit e;
    l = 0; c = 0; e = 1'b0;
    if (s1.rst || s2.rst) return '0;
    if (s2.burst) begin
      e = 1'b1;
      c = s1.odd ? s1.acc - BPH : s1.acc + BPH;
    end else if (!s2.blank) begin
      l = s2.luma;
      if (s2.en) begin
        e = 1'b1;
        c = s1.odd ? s1.acc - s2.phase : s1.acc + s2.phase;
      end
    end
    c = ((c % MOD) + MOD) % MOD;
    return {l[4:0], c[4:0], e, s2.vld};
  endfunction

  task automatic cycle();
    snap_t s;
    s.rst   = !rst_n;
    s.vld   = pix_valid;
    s.blank = blank;
    s.burst = burst;
    s.luma  = m_luma[pixel];
    s.phase = m_phase[pixel];
    s.en    = m_en[pixel];
    s.acc   = (since_rst * INC) % MOD;
    s.odd   = (PAL != 0) && ((lines_since_rst % 2) == 1);
    hist.push_back(s);
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        m_luma[i] = def_luma[i]; m_phase[i] = def_phase[i]; m_en[i] = def_en[i];
      end
      since_rst = 0;
      lines_since_rst = 0;
    end else begin
      if (cfg_we) begin
        m_luma[cfg_addr]  = int'(cfg_data[4:0]);
        m_phase[cfg_addr] = int'(cfg_data[9:5]);
        m_en[cfg_addr]    = cfg_data[10];
      end
      since_rst++;
      if (line_start) lines_since_rst++;
    end
    @(posedge clk);
    #1;
    if (hist.size() >= 2) exp_out = expect_out(hist[$-1], hist[$]);
  endtask

  task automatic idle();
    pix_valid = 1'b0; pixel = '0; blank = 1'b0; burst = 1'b0; line_start = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
`ifdef VICII_PALETTE_READBACK_EN
    cfg_re = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pix_valid = 1'b1; pixel = 4'($urandom); cfg_we = 1'b1; cfg_data = 11'($urandom);
      cycle();
      if (i > 0) begin
        ncmp++;
        if (got !== 12'h000) begin
          nfail++;
          $display("FAIL reset_outputs cyc %0d: got %h want %h", i, got, 12'h000);
        end
      end
    end
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_lookup();
    do_reset();
    pix_valid = 1'b1; pixel = 4'd1;
    cycle();
    idle();
    cycle();
    ncmp++;
    if (got !== {5'd31, 5'd0, 1'b0, 1'b1}) begin
      nfail++;
      $display("FAIL lookup_white: got %h want %h", got, {5'd31, 5'd0, 1'b0, 1'b1});
    end
  endtask

  task automatic test_rotation();
    do_reset();
    pix_valid = 1'b1; pixel = 4'd2;
    cycle();
    idle();
    cycle();
    ncmp++;
    if (got !== {5'd10, 5'h0D, 1'b1, 1'b1}) begin
      nfail++;
      $display("FAIL rotate_even: got %h want %h", got, {5'd10, 5'h0D, 1'b1, 1'b1});
    end
    do_reset();
    pix_valid = 1'b1; pixel = 4'd2; line_start = 1'b1;
    cycle();
    idle();
    cycle();
    ncmp++;
    if (got !== {5'd10, 5'h1B, 1'b1, 1'b1}) begin
      nfail++;
      $display("FAIL rotate_odd: got %h want %h", got, {5'd10, 5'h1B, 1'b1, 1'b1});
    end
  endtask

  task automatic test_read_before_write();
    do_reset();
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = {1'b1, 5'h03, 5'd20};
    pix_valid = 1'b1; pixel = 4'd0;
    cycle();
    cfg_we = 1'b0;
    cycle();
    ncmp++;
    if (got !== {5'd0, 5'd0, 1'b0, 1'b1}) begin
      nfail++;
      $display("FAIL rbw_old_entry: got %h want %h", got, {5'd0, 5'd0, 1'b0, 1'b1});
    end
    idle();
    cycle();
    ncmp++;
    if (got !== {5'd20, 5'h0B, 1'b1, 1'b1}) begin
      nfail++;
      $display("FAIL rbw_new_entry: got %h want %h", got, {5'd20, 5'h0B, 1'b1, 1'b1});
    end
  endtask

  task automatic test_blank_burst();
    do_reset();
    pix_valid = 1'b1; pixel = 4'd7; blank = 1'b1;
    cycle();
    burst = 1'b1;
    cycle();
    ncmp++;
    if (got !== {5'd0, 5'd0, 1'b0, 1'b1}) begin
      nfail++;
      $display("FAIL blank: got %h want %h", got, {5'd0, 5'd0, 1'b0, 1'b1});
    end
    idle();
    cycle();
    ncmp++;
    if (got !== {5'd0, 5'h18, 1'b1, 1'b1}) begin
      nfail++;
      $display("FAIL burst_over_blank: got %h want %h", got, {5'd0, 5'h18, 1'b1, 1'b1});
    end
  endtask

  task automatic test_reset_midstream();
    idle();
    cfg_we = 1'b1; cfg_addr = 4'd5; cfg_data = {1'b0, 5'h00, 5'd3};
    cycle();
    idle();
    pix_valid = 1'b1; pixel = 4'd5;
    cycle();
    cycle();
    ncmp++;
    if (got !== {5'd3, 5'd0, 1'b0, 1'b1}) begin
      nfail++;
      $display("FAIL rewrite_entry5: got %h want %h", got, {5'd3, 5'd0, 1'b0, 1'b1});
    end
    rst_n = 1'b0;
    cycle();
    ncmp++;
    if (got !== 12'h000) begin
      nfail++;
      $display("FAIL midstream_reset_out: got %h want %h", got, 12'h000);
    end
    rst_n = 1'b1;
    cycle();
    idle();
    cycle();
    ncmp++;
    if (got !== {5'd16, 5'h16, 1'b1, 1'b1}) begin
      nfail++;
      $display("FAIL entry5_default_restored: got %h want %h", got, {5'd16, 5'h16, 1'b1, 1'b1});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      pix_valid = 1'b1; pixel = 4'($urandom);
      cfg_we = 1'b1; cfg_addr = pixel; cfg_data = 11'($urandom);
      line_start = (i % 5) == 0;
      cycle();
      ncmp++;
      if (got !== exp_out) begin
        nfail++;
        $display("FAIL back_to_back cyc %0d: got %h want %h", i, got, exp_out);
      end
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_n      = ($urandom % 150) != 0;
      pix_valid  = ($urandom % 4) != 0;
      pixel      = 4'($urandom);
      blank      = ($urandom % 8) == 0;
      burst      = ($urandom % 10) == 0;
      line_start = ($urandom % 12) == 0;
      cfg_we     = ($urandom % 6) == 0;
      cfg_addr   = 4'($urandom);
      cfg_data   = 11'($urandom);
      cycle();
      ncmp++;
      if (got !== exp_out) begin
        nfail++;
        $display("FAIL random cyc %0d: got %h want %h", i, got, exp_out);
      end
    end
    rst_n = 1'b1;
    idle();
  endtask

`ifdef VICII_PALETTE_READBACK_EN
  task automatic test_readback();
    do_reset();
    cfg_re = 1'b1; cfg_addr = 4'd13;
    cycle();
    cfg_re = 1'b0; cfg_addr = 4'd1;
    ncmp++;
    if (cfg_rdata !== {1'b1, 5'h12, 5'd24}) begin
      nfail++;
      $display("FAIL readback_13: got %h want %h", cfg_rdata, {1'b1, 5'h12, 5'd24});
    end
    cycle();
    ncmp++;
    if (cfg_rdata !== {1'b1, 5'h12, 5'd24}) begin
      nfail++;
      $display("FAIL readback_hold: got %h want %h", cfg_rdata, {1'b1, 5'h12, 5'd24});
    end
    idle();
  endtask
`endif

  initial begin
    test_reset();
    test_lookup();
    test_rotation();
    test_read_before_write();
    test_blank_burst();
    test_reset_midstream();
    test_back_to_back();
    test_random();
`ifdef VICII_PALETTE_READBACK_EN
    test_readback();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
